// File: rtl/arcade_input_pkg.sv
// Shared constants for arcade_input_map: PS/2 scancodes, joystick word layout, DIP index.
// Also holds the held-key state type and the scancode decoder.
package arcade_input_pkg;

  localparam logic [7:0] SC_P0_U = 8'h75, SC_P0_D = 8'h72, SC_P0_L = 8'h6B, SC_P0_R = 8'h74;
  localparam logic [7:0] SC_P0_B0 = 8'h14, SC_P0_B1 = 8'h11, SC_P0_B2 = 8'h29;
  localparam logic [7:0] SC_P0_START_A = 8'h05, SC_P0_START_B = 8'h16;
  localparam logic [7:0] SC_P0_COIN_A = 8'h76, SC_P0_COIN_B = 8'h2E;
  localparam logic [7:0] SC_P1_U = 8'h2D, SC_P1_D = 8'h2B, SC_P1_L = 8'h23, SC_P1_R = 8'h34;
  localparam logic [7:0] SC_P1_B0 = 8'h1C, SC_P1_B1 = 8'h1B, SC_P1_B2 = 8'h15;
  localparam logic [7:0] SC_P1_START_A = 8'h06, SC_P1_START_B = 8'h1E, SC_P1_COIN = 8'h36;
  localparam logic [7:0] SC_P2_START = 8'h26, SC_P2_COIN = 8'h3D;
  localparam logic [7:0] SC_P3_START = 8'h25, SC_P3_COIN = 8'h3E;

  localparam int JB_R = 0, JB_L = 1, JB_D = 2, JB_U = 3;
  localparam int JB_BTN0 = 4, JB_START = 8, JB_COIN = 9;

  localparam int DIR_R = 0, DIR_L = 1, DIR_D = 2, DIR_U = 3;

  localparam logic [7:0] DIP_IOCTL_INDEX = 8'd254;

  typedef struct packed {
    logic       coin;
    logic       start;
    logic [2:0] btn;
    logic [3:0] dir;
  } key_state_t;

  // bit_idx uses the joystick word numbering so keys and joystick share one layout.
  typedef struct packed {
    logic       hit;
    logic [1:0] player;
    logic [3:0] bit_idx;
  } key_dec_t;

  function automatic key_dec_t decode_key(input logic [7:0] code);
    key_dec_t d;
    d = '0;
    case (code)
      SC_P0_U:       d = '{1'b1, 2'd0, 4'(JB_U)};
      SC_P0_D:       d = '{1'b1, 2'd0, 4'(JB_D)};
      SC_P0_L:       d = '{1'b1, 2'd0, 4'(JB_L)};
      SC_P0_R:       d = '{1'b1, 2'd0, 4'(JB_R)};
      SC_P0_B0:      d = '{1'b1, 2'd0, 4'(JB_BTN0)};
      SC_P0_B1:      d = '{1'b1, 2'd0, 4'(JB_BTN0 + 1)};
      SC_P0_B2:      d = '{1'b1, 2'd0, 4'(JB_BTN0 + 2)};
      SC_P0_START_A,
      SC_P0_START_B: d = '{1'b1, 2'd0, 4'(JB_START)};
      SC_P0_COIN_A,
      SC_P0_COIN_B:  d = '{1'b1, 2'd0, 4'(JB_COIN)};
      SC_P1_U:       d = '{1'b1, 2'd1, 4'(JB_U)};
      SC_P1_D:       d = '{1'b1, 2'd1, 4'(JB_D)};
      SC_P1_L:       d = '{1'b1, 2'd1, 4'(JB_L)};
      SC_P1_R:       d = '{1'b1, 2'd1, 4'(JB_R)};
      SC_P1_B0:      d = '{1'b1, 2'd1, 4'(JB_BTN0)};
      SC_P1_B1:      d = '{1'b1, 2'd1, 4'(JB_BTN0 + 1)};
      SC_P1_B2:      d = '{1'b1, 2'd1, 4'(JB_BTN0 + 2)};
      SC_P1_START_A,
      SC_P1_START_B: d = '{1'b1, 2'd1, 4'(JB_START)};
      SC_P1_COIN:    d = '{1'b1, 2'd1, 4'(JB_COIN)};
      SC_P2_START:   d = '{1'b1, 2'd2, 4'(JB_START)};
      SC_P2_COIN:    d = '{1'b1, 2'd2, 4'(JB_COIN)};
      SC_P3_START:   d = '{1'b1, 2'd3, 4'(JB_START)};
      SC_P3_COIN:    d = '{1'b1, 2'd3, 4'(JB_COIN)};
      default:       d = '0;
    endcase
    return d;
  endfunction

  function automatic key_state_t set_key(input key_state_t k, input logic [3:0] idx,
                                         input logic v);
    key_state_t r;
    r = k;
    case (idx)
      4'd0:    r.dir[0] = v;
      4'd1:    r.dir[1] = v;
      4'd2:    r.dir[2] = v;
      4'd3:    r.dir[3] = v;
      4'd4:    r.btn[0] = v;
      4'd5:    r.btn[1] = v;
      4'd6:    r.btn[2] = v;
      4'd8:    r.start  = v;
      4'd9:    r.coin   = v;
      default: r = k;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] key_to_joy(input key_state_t k);
    logic [15:0] w;
    w           = '0;
    w[3:0]      = k.dir;
    w[6:4]      = k.btn;
    w[JB_START] = k.start;
    w[JB_COIN]  = k.coin;
    return w;
  endfunction

endpackage

// File: rtl/coin_pulse_stretch.sv
// Turns a rising coin edge into a fixed COIN_PULSE-cycle high pulse; edges while busy are dropped.
// Output rises the cycle after the edge is sampled; reset loads the edge history from the live input.
module coin_pulse_stretch #(
  parameter int COIN_PULSE = 400000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic coin_i,
  output logic pulse_o
);

  localparam int CW = $clog2(COIN_PULSE + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q;
  logic          pulse_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else if (coin_i && !prev_q) begin
      cnt_d = CW'(COIN_PULSE);
    end
  end

  // Seeding prev_q from the input on reset means a coin held through reset is not a new edge.
  always_ff @(posedge clk_sys) begin
    prev_q <= coin_i;
    if (reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= (cnt_d != '0);
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/arcade_input_map.sv
// Merges PS/2 held-key state with per-player joystick words, SOCD cleaning, coin stretch, DIP bank.
// Optional autofire on button 0 when ARCADE_INPUT_AUTOFIRE_EN is defined; all outputs registered.
module arcade_input_map
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BTNS    = 1,
  parameter int DIP_BYTES   = 8,
  parameter int COIN_PULSE  = 400000,
  parameter int SOCD_MODE   = 1
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  ,
  parameter int AUTOFIRE_DIV = 1333333
`endif
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic [10:0]                   ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]     joy_in,
  input  logic                          share,
  input  logic                          ioctl_wr,
  input  logic [7:0]                    ioctl_index,
  input  logic [24:0]                   ioctl_addr,
  input  logic [7:0]                    ioctl_dout,
  output logic [8*DIP_BYTES-1:0]        dip,
  output logic [4*NUM_PLAYERS-1:0]      p_dir,
  output logic [NUM_BTNS*NUM_PLAYERS-1:0] p_btn,
  output logic [NUM_PLAYERS-1:0]        p_start,
  output logic [NUM_PLAYERS-1:0]        p_coin
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  ,
  input  logic [NUM_PLAYERS-1:0]        autofire
`endif
);

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4) begin : g_bad_players
    $error("arcade_input_map: NUM_PLAYERS must be 1..4");
  end
  if (NUM_BTNS < 1 || NUM_BTNS > 4) begin : g_bad_btns
    $error("arcade_input_map: NUM_BTNS must be 1..4");
  end
  if (DIP_BYTES < 1 || DIP_BYTES > 8) begin : g_bad_dip
    $error("arcade_input_map: DIP_BYTES must be 1..8");
  end
  if (COIN_PULSE < 2) begin : g_bad_coin
    $error("arcade_input_map: COIN_PULSE must be >= 2");
  end
  if (SOCD_MODE < 0 || SOCD_MODE > 1) begin : g_bad_socd
    $error("arcade_input_map: SOCD_MODE must be 0 or 1");
  end

  logic       old_toggle_q;
  logic       key_evt;
  key_dec_t   dec;
  key_state_t key_q [NUM_PLAYERS];
  key_state_t key_d [NUM_PLAYERS];

  assign dec     = decode_key(ps2_key[7:0]);
  assign key_evt = (ps2_key[10] != old_toggle_q);

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      key_d[p] = key_q[p];
      if (key_evt && dec.hit && int'(dec.player) == p) begin
        key_d[p] = set_key(key_q[p], dec.bit_idx, ps2_key[9]);
      end
    end
  end

  logic [NUM_PLAYERS-1:0][15:0]          raw, mrg;
  logic [NUM_PLAYERS-1:0][NUM_BTNS-1:0]  btn_m, btn_c;
  logic [4*NUM_PLAYERS-1:0]              p_dir_q, p_dir_d;
  logic [NUM_BTNS*NUM_PLAYERS-1:0]       p_btn_q, p_btn_d;
  logic [NUM_PLAYERS-1:0]                p_start_q, p_start_d;
  logic [8*DIP_BYTES-1:0]                dip_q, dip_d;

  // Share ORs player 0's physical inputs into everyone, so SOCD sees the combined word.
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      raw[p] = key_to_joy(key_q[p]) | joy_in[16*p +: 16];
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      mrg[p] = raw[p];
      if (share && p > 0) begin
        mrg[p] = raw[p] | raw[0];
      end
      btn_m[p] = mrg[p][JB_BTN0 +: NUM_BTNS];
    end
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int AW = $clog2(AUTOFIRE_DIV + 1);

  if (AUTOFIRE_DIV < 1) begin : g_bad_af
    $error("arcade_input_map: AUTOFIRE_DIV must be >= 1");
  end

  logic [NUM_PLAYERS-1:0][AW-1:0] af_cnt_q, af_cnt_d;
  logic [NUM_PLAYERS-1:0]         af_ph_q, af_ph_d, af_hold;

  // Phase idles high so every fresh press starts with a full high half-period.
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      af_hold[p]  = autofire[p] & btn_m[p][0];
      af_cnt_d[p] = '0;
      af_ph_d[p]  = 1'b1;
      if (af_hold[p]) begin
        if (af_cnt_q[p] == AW'(AUTOFIRE_DIV - 1)) begin
          af_ph_d[p] = ~af_ph_q[p];
        end else begin
          af_cnt_d[p] = af_cnt_q[p] + AW'(1);
          af_ph_d[p]  = af_ph_q[p];
        end
      end
      btn_c[p]    = btn_m[p];
      btn_c[p][0] = af_hold[p] ? af_ph_q[p] : btn_m[p][0];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_cnt_q <= '0;
      af_ph_q  <= '1;
    end else begin
      af_cnt_q <= af_cnt_d;
      af_ph_q  <= af_ph_d;
    end
  end
`else
  assign btn_c = btn_m;
`endif

  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      p_dir_d[4*p +: 4] = mrg[p][3:0];
      if (SOCD_MODE == 1) begin
        if (mrg[p][JB_U] && mrg[p][JB_D]) begin
          p_dir_d[4*p + DIR_U] = 1'b0;
          p_dir_d[4*p + DIR_D] = 1'b0;
        end
        if (mrg[p][JB_L] && mrg[p][JB_R]) begin
          p_dir_d[4*p + DIR_L] = 1'b0;
          p_dir_d[4*p + DIR_R] = 1'b0;
        end
      end
      p_btn_d[NUM_BTNS*p +: NUM_BTNS] = btn_c[p];
      p_start_d[p] = mrg[p][JB_START];
    end
  end

  always_comb begin
    dip_d = dip_q;
    for (int n = 0; n < DIP_BYTES; n++) begin
      if (ioctl_wr && ioctl_index == DIP_IOCTL_INDEX && ioctl_addr == 25'(n)) begin
        dip_d[8*n +: 8] = ioctl_dout;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    old_toggle_q <= ps2_key[10];
    if (reset) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        key_q[p] <= '0;
      end
      p_dir_q   <= '0;
      p_btn_q   <= '0;
      p_start_q <= '0;
      dip_q     <= '0;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        key_q[p] <= key_d[p];
      end
      p_dir_q   <= p_dir_d;
      p_btn_q   <= p_btn_d;
      p_start_q <= p_start_d;
      dip_q     <= dip_d;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_coin
    coin_pulse_stretch #(
      .COIN_PULSE(COIN_PULSE)
    ) u_coin (
      .clk_sys(clk_sys),
      .reset  (reset),
      .coin_i (mrg[g][JB_COIN]),
      .pulse_o(p_coin[g])
    );
  end

  // Extended-key flag and spare joystick bits have no consumer.
  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], mrg};

  assign dip     = dip_q;
  assign p_dir   = p_dir_q;
  assign p_btn   = p_btn_q;
  assign p_start = p_start_q;

endmodule

// File: doc/arcade_input_map.md
Name: arcade_input_map

Overview:
- Parametrised successor to the per-core hand-coded keyboard/joystick merge logic.
- Decodes PS/2 key events into held-key state for up to 4 players and merges them with per-player joystick words.
- Adds player-share mode, SOCD cleaning, coin pulse stretching and a loadable DIP bank.
- Sits in the emu top between hps_io/joy_db9md and the game core; all outputs are registered.

Parameters:
- NUM_PLAYERS, 2, players served (1..4).
- NUM_BTNS, 1, fire buttons per player (1..4; keyboard covers buttons 0..2 only).
- DIP_BYTES, 8, DIP bank bytes (1..8).
- COIN_PULSE, 400000, coin output high time in clk_sys cycles (≥2).
- SOCD_MODE, 1, 0 = pass opposing directions through; 1 = opposing pair resolves to neither.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended (ignored), [7:0] scancode.
- joy_in  in  16*NUM_PLAYERS  per-player word: [0]R [1]L [2]D [3]U, [4+k] button k, [8] start, [9] coin.
- share  in  1  1 = player 0 physical inputs also drive every other player.
- ioctl_wr  in  1  download write strobe.
- ioctl_index  in  8  download index.
- ioctl_addr  in  25  download byte address.
- ioctl_dout  in  8  download data.
- dip  out  8*DIP_BYTES  DIP bank, byte n at [8n+7:8n].
- p_dir  out  4*NUM_PLAYERS  per player {U,D,L,R}.
- p_btn  out  NUM_BTNS*NUM_PLAYERS  fire buttons.
- p_start  out  NUM_PLAYERS  start.
- p_coin  out  NUM_PLAYERS  stretched coin.

Behaviour:
- Reset values: all outputs 0, key state 0, coin counters idle, dip all 0. On reset, old_toggle loads ps2_key[10], so no event is taken on the first cycle after reset.
- Key event:
  - Event when ps2_key[10] != old_toggle; old_toggle updates every cycle.
  - On an event, the matching key state bit is set to ps2_key[9].
  - Unmapped codes: no effect.
  - Key state is visible on outputs 2 cycles after the toggle edge.
- Key map:
  - P0: 75/72/6B/74 = U/D/L/R; 14/11/29 = btn0..2; start 05,16; coin 76,2E.
  - P1: 2D/2B/23/34 = U/D/L/R; 1C/1B/15 = btn0..2; start 06,1E; coin 36.
  - P2: start 26, coin 3D. P3: start 25, coin 3E.
- Merge: raw[p] = key[p] | joy_in[p]. When share=1, raw[p] |= raw[0] for p>0. Output latency 1 cycle from joy_in/share.
- SOCD: with SOCD_MODE=1, U&D both set gives U=D=0; L&R both set gives L=R=0. Each axis is resolved independently.
- Coin (per player):
  - A rising edge of merged coin while idle drives p_coin high for exactly COIN_PULSE cycles, starting the next cycle.
  - Edges during an active pulse are ignored.
  - Holding the input does not extend the pulse.
  - A new pulse needs a low-then-high edge seen after the pulse ends.
  - Reset mid-pulse drops p_coin the next cycle.
- DIP: on ioctl_wr && ioctl_index==254 && ioctl_addr < DIP_BYTES, byte ioctl_addr is written with ioctl_dout, visible next cycle. All other writes are ignored, including addr ≥ DIP_BYTES and other indices. Same-cycle key event and DIP write are independent.
- Elaboration error if a parameter is out of range.

Optional Feature:
- Macro ARCADE_INPUT_AUTOFIRE_EN.
- Defined:
  - Adds input autofire [NUM_PLAYERS] and parameter AUTOFIRE_DIV (default 1333333).
  - While autofire[p]=1 and btn0 is held, p_btn bit 0 for player p follows a square wave: high AUTOFIRE_DIV cycles, then low AUTOFIRE_DIV cycles, phase restarting high on press.
  - Release forces the bit to 0 the next cycle.
- Undefined: port and counter absent; btn0 passes as merged.

Decomposition:
- Package arcade_input_pkg:
  - Scancode localparams.
  - Joystick bit indices (JB_R..JB_COIN).
  - DIR_* order constants.
  - DIP ioctl index 254.
  - Typedef of per-player key-state struct.
- One sub-module: coin_pulse_stretch (edge detect + down-counter, parameter COIN_PULSE), instantiated NUM_PLAYERS times.

Test Plan:
- Reset, then toggle ps2_key with {pressed=1, code 74} → p_dir[0] R=1 after 2 cycles; toggle with pressed=0 → R=0. Repeating the same toggle value produces no event.
- joy_in P0 = 0x00C (U+D), SOCD_MODE=1 → p_dir[0]=0; add bit0 → only R=1.
- COIN_PULSE=5: joy_in P1 bit9 high for 20 cycles → p_coin[1] high exactly 5 cycles, once; low 1 cycle then high → second pulse.
- ioctl writes index 254, addr 0..9, data 0xA0+addr, DIP_BYTES=8 → dip = A7..A0; addrs 8,9 and an index-0 write leave dip unchanged.
- share=1, keyboard F1 plus key 29 → p_start[0]=p_start[1]=1, p_btn btn2 set for both players (NUM_BTNS=3); share=0 → P0 only.
- Reset asserted on cycle 2 of an active coin pulse → p_coin=0 next cycle; no pulse after reset while coin is held until it is released and re-pressed.
